// File: rtl/fsrc_sysref_flywheel.sv
// SYSREF qualifier and flywheel: checks raw edge spacing, locks a phase counter
// to it and regenerates a clean single-cycle sysref_int pulse once per period.
module fsrc_sysref_flywheel #(
  parameter int PERIOD_WIDTH = 16,
  parameter int LOCK_COUNT   = 4,
  parameter int ERR_LIMIT    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sysref,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    err_clr,
  output logic                    sysref_int,
  output logic                    locked,
  output logic                    err_miss,
  output logic                    err_phase,
  output logic [7:0]              err_count,
  output logic                    lock_lost
);
  localparam int PW = PERIOD_WIDTH;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(ERR_LIMIT + 1);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] ERR_N  = BW'(ERR_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

  state_t          r_state, w_state_n;
  logic            r_sysref_d;
  logic [PW-1:0]   r_cnt, w_cnt_n;
  logic [PW-1:0]   r_period_q, w_period_n;
  logic [PW-1:0]   r_ph, w_ph_n;
  logic            r_have_ref, w_have_n;
  logic [GW-1:0]   r_good_cnt, w_good_n;
  logic [BW-1:0]   r_bad_cnt, w_bad_n;
  logic            r_sysref_int, w_int_n;
  logic            r_locked, w_locked_n;
  logic            r_lock_lost, w_lost_n;
  logic            r_err_miss, w_miss_n;
  logic            r_err_phase, w_phase_n;
  logic [7:0]      r_err_count, w_count_n;

  logic            w_edge, w_good_spc, w_slot, w_per_ok;
  logic            w_miss_ev, w_phase_ev;
  logic [PW-1:0]   w_pm1;
  logic [GW-1:0]   w_good_inc;
  logic [BW-1:0]   w_bad_inc;

  assign w_edge     = sysref & ~r_sysref_d;
  assign w_pm1      = r_period_q - 1'b1;
  assign w_good_spc = w_edge && (r_cnt == w_pm1);
  assign w_slot     = (r_ph == w_pm1);
  assign w_per_ok   = (r_period_q >= PW'(2));
  assign w_good_inc = r_good_cnt + 1'b1;
  assign w_bad_inc  = r_bad_cnt + 1'b1;

  always_comb begin
    w_state_n  = r_state;
    w_period_n = r_period_q;
    w_ph_n     = r_ph;
    w_have_n   = r_have_ref;
    w_good_n   = r_good_cnt;
    w_bad_n    = r_bad_cnt;
    w_int_n    = 1'b0;
    w_locked_n = r_locked;
    w_lost_n   = 1'b0;
    w_miss_ev  = 1'b0;
    w_phase_ev = 1'b0;
    if (!enable)         w_cnt_n = '0;
    else if (w_edge)     w_cnt_n = '0;
    else if (&r_cnt)     w_cnt_n = r_cnt;
    else                 w_cnt_n = r_cnt + 1'b1;

    if (!enable) begin
      w_state_n  = S_IDLE;
      w_locked_n = 1'b0;
      w_ph_n     = '0;
      w_good_n   = '0;
      w_bad_n    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_period_n = period;
          w_have_n   = 1'b0;
          w_good_n   = '0;
          w_state_n  = S_ACQ;
        end
        S_ACQ: begin
          if (w_edge) begin
            if (!r_have_ref) begin
              w_have_n = 1'b1;
            end else if (w_good_spc) begin
              if (r_good_cnt != LOCK_N) w_good_n = w_good_inc;
              // Periods below 2 cannot produce a meaningful slot, so never lock.
              if (w_good_inc == LOCK_N && w_per_ok) begin
                w_state_n  = S_LOCK;
                w_ph_n     = '0;
                w_int_n    = 1'b1;
                w_locked_n = 1'b1;
                w_bad_n    = '0;
              end
            end else begin
              w_good_n = '0;
            end
          end
        end
        S_LOCK: begin
          w_ph_n  = w_slot ? '0 : r_ph + 1'b1;
          w_int_n = w_slot;
          if (w_slot && w_edge) begin
            w_bad_n = '0;
          end else if (w_slot || w_edge) begin
            w_miss_ev  = w_slot;
            w_phase_ev = ~w_slot;
            w_bad_n    = w_bad_inc;
            if (w_bad_inc == ERR_N) begin
              w_state_n  = S_ACQ;
              w_have_n   = 1'b0;
              w_good_n   = '0;
              w_bad_n    = '0;
              w_ph_n     = '0;
              w_locked_n = 1'b0;
              w_lost_n   = 1'b1;
              w_int_n    = 1'b0;
            end
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end

    // A clear in the same cycle as an error event wins; the event is dropped.
    w_miss_n  = r_err_miss;
    w_phase_n = r_err_phase;
    w_count_n = r_err_count;
    if (err_clr) begin
      w_miss_n  = 1'b0;
      w_phase_n = 1'b0;
      w_count_n = '0;
    end else begin
      if (w_miss_ev)  w_miss_n  = 1'b1;
      if (w_phase_ev) w_phase_n = 1'b1;
      if ((w_miss_ev || w_phase_ev) && r_err_count != 8'hFF) w_count_n = r_err_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sysref_d   <= 1'b1;
      r_cnt        <= '0;
      r_period_q   <= '0;
      r_ph         <= '0;
      r_have_ref   <= 1'b0;
      r_good_cnt   <= '0;
      r_bad_cnt    <= '0;
      r_sysref_int <= 1'b0;
      r_locked     <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_err_miss   <= 1'b0;
      r_err_phase  <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_state_n;
      r_sysref_d   <= sysref;
      r_cnt        <= w_cnt_n;
      r_period_q   <= w_period_n;
      r_ph         <= w_ph_n;
      r_have_ref   <= w_have_n;
      r_good_cnt   <= w_good_n;
      r_bad_cnt    <= w_bad_n;
      r_sysref_int <= w_int_n;
      r_locked     <= w_locked_n;
      r_lock_lost  <= w_lost_n;
      r_err_miss   <= w_miss_n;
      r_err_phase  <= w_phase_n;
      r_err_count  <= w_count_n;
    end
  end

  assign sysref_int = r_sysref_int;
  assign locked     = r_locked;
  assign err_miss   = r_err_miss;
  assign err_phase  = r_err_phase;
  assign err_count  = r_err_count;
  assign lock_lost  = r_lock_lost;
endmodule

// File: tb/tb_fsrc_sysref_flywheel.sv
// Directed bench for fsrc_sysref_flywheel: scenario table plus hand sequences
// for disable/relock, error saturation, err_clr priority and mid-run reset.
module tb_fsrc_sysref_flywheel;
  logic        clk = 1'b0;
  logic        reset, sysref, enable, err_clr;
  logic [15:0] period;
  logic        sysref_int, locked, err_miss, err_phase, lock_lost;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  fsrc_sysref_flywheel dut (
    .clk(clk), .reset(reset), .sysref(sysref), .enable(enable), .period(period),
    .err_clr(err_clr), .sysref_int(sysref_int), .locked(locked), .err_miss(err_miss),
    .err_phase(err_phase), .err_count(err_count), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  // Raw edges sit at cycle 4 + k*spacing (k < n), minus 'drop', plus 'extra'.
  typedef struct {
    string nm;
    int period; int spacing; int n; int drop; int extra; bit hold_hi; int ncyc;
    int e_pulses; int e_first; int e_locked; int e_miss; int e_phase; int e_cnt; int e_lost;
  } row_t;

  row_t rows[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset(input bit hi);
    reset = 1'b1; enable = 1'b0; err_clr = 1'b0; sysref = hi; period = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic run_row(input row_t r, input bit rst);
    int pulses, first, flk, lost, last, sp_bad;
    bit e;
    pulses = 0; first = 0; flk = 0; lost = 0; last = -1; sp_bad = 0;
    if (rst) do_reset(r.hold_hi);
    for (int c = 0; c < r.ncyc; c++) begin
      enable = 1'b1;
      // Only the value at enable time may matter; later changes are junk.
      period = (c == 0) ? 16'(r.period) : 16'hFFFF;
      e = (c >= 4) && ((c - 4) % r.spacing == 0) && ((c - 4) / r.spacing < r.n)
          && ((c - 4) / r.spacing != r.drop);
      sysref = e || (c == r.extra) || (r.hold_hi && c < 2);
      tick();
      if (sysref_int) begin
        pulses++;
        if (first == 0) first = c + 1;
        if (last >= 0 && (c + 1 - last) != r.period) sp_bad++;
        last = c + 1;
      end
      if (locked && flk == 0) flk = c + 1;
      if (lock_lost) lost++;
    end
    sysref = 1'b0;
    chk({r.nm, " pulses"},      pulses, r.e_pulses);
    chk({r.nm, " first_pulse"}, first,  r.e_first);
    chk({r.nm, " first_lock"},  flk,    r.e_first);
    chk({r.nm, " spacing"},     sp_bad, 0);
    chk({r.nm, " locked"},      int'(locked),    r.e_locked);
    chk({r.nm, " err_miss"},    int'(err_miss),  r.e_miss);
    chk({r.nm, " err_phase"},   int'(err_phase), r.e_phase);
    chk({r.nm, " err_count"},   int'(err_count), r.e_cnt);
    chk({r.nm, " lock_lost"},   lost,            r.e_lost);
  endtask

  initial begin
    int pulses;
    //           name        per sp  n  drop extra hi ncyc  pul first lk mi ph cnt lost
    rows[0] = '{"lock16",    16, 16, 10, -1, -1,  0, 160,  6, 69,  1, 0, 0, 0, 0};
    rows[1] = '{"drop1",     16, 16, 10,  7, -1,  0, 160,  6, 69,  1, 1, 0, 1, 0};
    rows[2] = '{"stop",      16, 16,  6, -1, -1,  0, 160,  4, 69,  0, 1, 0, 3, 1};
    rows[3] = '{"extra",     16, 16, 10, -1, 90,  0, 160,  6, 69,  1, 0, 1, 1, 0};
    rows[4] = '{"wrongsp",   16, 15, 10, -1, -1,  1, 160,  0,  0,  0, 0, 0, 0, 0};
    rows[5] = '{"per1",       1,  2, 20, -1, -1,  0,  60,  0,  0,  0, 0, 0, 0, 0};
    rows[6] = '{"per2",       2,  2, 10, -1, -1,  0,  40,  8, 13,  0, 1, 0, 3, 1};
    rows[7] = '{"pre_dis",   16, 16, 10, -1, -1,  0,  84,  1, 69,  1, 0, 0, 0, 0};
    rows[8] = '{"relock32",  32, 32,  8, -1, -1,  0, 240,  4, 133, 1, 0, 0, 0, 0};
    rows[9] = '{"lock4",      4,  4,  5, -1, -1,  0,  21,  1, 21,  1, 0, 0, 0, 0};

    do_reset(1'b0);
    chk("reset outputs", int'({sysref_int, locked, err_miss, err_phase, lock_lost, err_count}), 0);

    for (int i = 0; i < 7; i++) run_row(rows[i], 1'b1);

    // Disable mid-run on a cycle that carries the expected edge.
    run_row(rows[7], 1'b1);
    sysref = 1'b1; enable = 1'b0;
    tick();
    chk("disable locked", int'(locked), 0);
    chk("disable sysref_int", int'(sysref_int), 0);
    sysref = 1'b0;
    run_row(rows[8], 1'b0);

    // Period 4: one phase error per period, healed by the good slot each time.
    run_row(rows[9], 1'b1);
    pulses = 0;
    for (int c = 21; c <= 1120; c++) begin
      sysref = (c % 2 == 0);
      tick();
      if (sysref_int) pulses++;
    end
    chk("sat err_count", int'(err_count), 255);
    chk("sat locked", int'(locked), 1);
    chk("sat err_phase", int'(err_phase), 1);
    chk("sat pulses", pulses, 275);
    sysref = 1'b0; tick();                  // c=1121
    sysref = 1'b1; err_clr = 1'b1; tick();  // c=1122, phase error collides with clear
    chk("clr err_count", int'(err_count), 0);
    chk("clr err_phase", int'(err_phase), 0);
    err_clr = 1'b0;
    sysref = 1'b0; tick();                  // c=1123
    sysref = 1'b1; tick();                  // c=1124 slot
    chk("clr slot pulse", int'(sysref_int), 1);
    sysref = 1'b0; tick();                  // c=1125
    sysref = 1'b1; tick();                  // c=1126 phase error
    chk("post clr err_count", int'(err_count), 1);
    chk("post clr err_phase", int'(err_phase), 1);
    chk("post clr locked", int'(locked), 1);

    reset = 1'b1; sysref = 1'b0;
    tick();
    chk("midrun reset outputs", int'({sysref_int, locked, err_miss, err_phase, lock_lost, err_count}), 0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
